reorder_buffer: RTL

Circular reorder buffer that closes the loop opened by the issue queue. Rename allocates an entry per instruction and receives the ROB index (`rob_tail`) that travels with the instruction through the issue queue and the FUs. FU results return on the common data bus tagged with that index and mark the entry complete. Results are served back to the issue queue as forwarded source operands (`data_rs_rob`/`valid_data_rs`), and completed entries are retired in program order to the ARF.

---
 rtl/constants.sv | 17 +
 rtl/rob_lookup.sv | 52 +++++
 rtl/reorder_buffer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/constants.sv
// Shared widths and the ROB entry record used by the reorder buffer and its lookup ports.
package constants;

    localparam int REG_SIZE      = 32;
    localparam int ROB_SIZE_LOG2 = 6;
    localparam int NUM_TAGS_LOG2 = 7;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic                     has_rd;
        logic [4:0]               arch_rd;
        logic [NUM_TAGS_LOG2-1:0] tag_rd;
        logic [REG_SIZE-1:0]      data;
    } rob_entry_t;

endpackage

// File: rtl/rob_lookup.sv
// One source-operand lookup: finds the live ROB entry producing lookup_tag and
// returns its stored result, or a same-cycle CDB result aimed at that entry.
module rob_lookup
    import constants::*;
#(
    parameter int ROB_SIZE    = 64,
    parameter int ISSUE_PORTS = 3
) (
    input  logic [ROB_SIZE-1:0]      live,
    input  logic [ROB_SIZE-1:0]      done,
    input  logic [NUM_TAGS_LOG2-1:0] tags     [ROB_SIZE],
    input  logic [REG_SIZE-1:0]      results  [ROB_SIZE],
    input  logic                     cdb_valid [0:ISSUE_PORTS-1],
    input  logic [ROB_SIZE_LOG2-1:0] cdb_rob   [0:ISSUE_PORTS-1],
    input  logic [REG_SIZE-1:0]      cdb_data  [0:ISSUE_PORTS-1],
    input  logic [NUM_TAGS_LOG2-1:0] lookup_tag,
    output logic [REG_SIZE-1:0]      fwd_data,
    output logic                     fwd_valid
);

    logic                     hit;
    logic [ROB_SIZE_LOG2-1:0] hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            if (live[i] && tags[i] == lookup_tag) begin
                hit     = 1'b1;
                hit_idx = ROB_SIZE_LOG2'(i);
            end
        end

        fwd_valid = 1'b0;
        fwd_data  = '0;
        if (hit) begin
            if (done[hit_idx]) begin
                fwd_valid = 1'b1;
                fwd_data  = results[hit_idx];
            end else begin
                // Later ports override earlier ones, matching the writeback priority.
                for (int unsigned p = 0; p < ISSUE_PORTS; p++) begin
                    if (cdb_valid[p] && cdb_rob[p] == hit_idx) begin
                        fwd_valid = 1'b1;
                        fwd_data  = cdb_data[p];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion,
// in-order retirement, plus operand forwarding for two source lookups.
module reorder_buffer
    import constants::*;
#(
    parameter int ROB_SIZE    = 64,
    parameter int ISSUE_PORTS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [NUM_TAGS_LOG2-1:0] alloc_tag_rd,
    input  logic [4:0]               alloc_arch_rd,
    input  logic                     alloc_has_rd,
    output logic [ROB_SIZE_LOG2-1:0] rob_tail,
    input  logic [NUM_TAGS_LOG2-1:0] lookup_tag    [0:1],
    output logic [REG_SIZE-1:0]      data_rs_rob   [0:1],
    output logic                     valid_data_rs [0:1],
    input  logic                     cdb_valid     [0:ISSUE_PORTS-1],
    input  logic [ROB_SIZE_LOG2-1:0] cdb_rob       [0:ISSUE_PORTS-1],
    input  logic [REG_SIZE-1:0]      cdb_data      [0:ISSUE_PORTS-1],
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic                     commit_has_rd,
    output logic [4:0]               commit_arch_rd,
    output logic [NUM_TAGS_LOG2-1:0] commit_tag,
    output logic [REG_SIZE-1:0]      commit_data,
    output logic [ROB_SIZE_LOG2:0]   rob_count,
    output logic                     rob_empty,
    output logic                     rob_full
);

    localparam int CNT_W = ROB_SIZE_LOG2 + 1;

    rob_entry_t                entries [ROB_SIZE];
    logic [ROB_SIZE_LOG2-1:0]  head;
    logic [ROB_SIZE_LOG2-1:0]  tail;
    logic [CNT_W-1:0]          count;
    logic                      alloc_fire;
    logic                      commit_fire;

    logic [ROB_SIZE-1:0]       live;
    logic [ROB_SIZE-1:0]       done_vec;
    logic [NUM_TAGS_LOG2-1:0]  tags    [ROB_SIZE];
    logic [REG_SIZE-1:0]       results [ROB_SIZE];

    assign rob_full    = (count == CNT_W'(ROB_SIZE));
    assign rob_empty   = (count == '0);
    assign rob_count   = count;
    assign rob_tail    = tail;
    assign alloc_ready = !rob_full;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign commit_valid   = entries[head].valid && entries[head].done && !flush;
    assign commit_fire    = commit_valid && commit_ready;
    assign commit_has_rd  = entries[head].has_rd;
    assign commit_arch_rd = entries[head].arch_rd;
    assign commit_tag     = entries[head].tag_rd;
    assign commit_data    = entries[head].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) entries[i].valid <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                entries[tail] <= '{valid: 1'b1, done: 1'b0, has_rd: alloc_has_rd,
                                   arch_rd: alloc_arch_rd, tag_rd: alloc_tag_rd, data: '0};
                tail <= tail + 1'b1;
            end
            for (int unsigned p = 0; p < ISSUE_PORTS; p++) begin
                if (cdb_valid[p] && entries[cdb_rob[p]].valid) begin
                    entries[cdb_rob[p]].done <= 1'b1;
                    entries[cdb_rob[p]].data <= cdb_data[p];
                end
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            live[i]     = entries[i].valid && entries[i].has_rd;
            done_vec[i] = entries[i].done;
            tags[i]     = entries[i].tag_rd;
            results[i]  = entries[i].data;
        end
    end

    rob_lookup #(.ROB_SIZE(ROB_SIZE), .ISSUE_PORTS(ISSUE_PORTS)) u_lookup0 (
        .live       (live),
        .done       (done_vec),
        .tags       (tags),
        .results    (results),
        .cdb_valid  (cdb_valid),
        .cdb_rob    (cdb_rob),
        .cdb_data   (cdb_data),
        .lookup_tag (lookup_tag[0]),
        .fwd_data   (data_rs_rob[0]),
        .fwd_valid  (valid_data_rs[0])
    );

    rob_lookup #(.ROB_SIZE(ROB_SIZE), .ISSUE_PORTS(ISSUE_PORTS)) u_lookup1 (
        .live       (live),
        .done       (done_vec),
        .tags       (tags),
        .results    (results),
        .cdb_valid  (cdb_valid),
        .cdb_rob    (cdb_rob),
        .cdb_data   (cdb_data),
        .lookup_tag (lookup_tag[1]),
        .fwd_data   (data_rs_rob[1]),
        .fwd_valid  (valid_data_rs[1])
    );

endmodule
